// File: rtl/spi_handler.sv
// spi_handler: command-bus to SPI master bridge; MISO bytes are buffered in a FWFT FIFO and returned on the upload port.
// Optional feature macro SPI_CFG_EN adds the CPOL/CPHA mode-config command; without it SPI mode 0 is fixed.
module spi_handler #(
    parameter int         CLK_DIV       = 8,
    parameter logic [7:0] CMD_SPI_XFER  = 8'h11,
    parameter logic [7:0] CMD_SPI_CFG   = 8'h12,
    parameter logic [7:0] UPLOAD_SOURCE = 8'h11,
    parameter int         FIFO_DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SHIFT, PUSH, CS_HOLD, CFG} state_t;

    state_t           state, next_state;
    logic [DIV_W-1:0] div;
    logic             phase;
    logic [2:0]       bit_cnt;
    logic [15:0]      remaining;
    logic [7:0]       tx_sr, rx_sr;
    logic             miso_p0, miso_p1;
    logic             cpol, cpha;
    logic             start_xfer, start_cfg, accept;
    logic             edge_tick, lead_edge, trail_edge, byte_done, sample_edge, update_edge;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full, fifo_empty, push, pop;
    logic             unused_inputs;

    assign unused_inputs = ^{cmd_data_index, cmd_done, CMD_SPI_CFG};

    assign start_xfer  = cmd_start && (cmd_type == CMD_SPI_XFER) && (cmd_length != 16'd0);
    assign accept      = cmd_data_valid && cmd_ready;
    assign edge_tick   = (state == SHIFT) && (div == DIV_LAST);
    assign lead_edge   = edge_tick && !phase;
    assign trail_edge  = edge_tick && phase;
    assign byte_done   = trail_edge && (bit_cnt == 3'd7);
    // CPHA=1 swaps which clock edge samples MISO and which updates MOSI
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign update_edge = cpha ? lead_edge : trail_edge;

`ifdef SPI_CFG_EN
    logic cfg_first;
    assign start_cfg = cmd_start && (cmd_type == CMD_SPI_CFG) && (cmd_length != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol      <= 1'b0;
            cpha      <= 1'b0;
            cfg_first <= 1'b0;
        end else if (state == IDLE && start_cfg) begin
            cfg_first <= 1'b1;
        end else if (state == CFG && accept) begin
            if (cfg_first) {cpol, cpha} <= cmd_data[1:0];
            cfg_first <= 1'b0;
        end
    end
`else
    assign start_cfg = 1'b0;
    assign cpol      = 1'b0;
    assign cpha      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_xfer) next_state = WAIT_BYTE;
                       else if (start_cfg) next_state = CFG;
            WAIT_BYTE: if (accept) next_state = SHIFT;
            SHIFT:     if (byte_done) next_state = PUSH;
            PUSH:      next_state = (remaining <= 16'd1) ? CS_HOLD : WAIT_BYTE;
            CS_HOLD:   if (div == DIV_LAST) next_state = IDLE;
            CFG:       if (accept && remaining <= 16'd1) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        case (state)
            IDLE, CFG: cmd_ready = 1'b1;
            WAIT_BYTE: cmd_ready = !fifo_full;
            default:   cmd_ready = 1'b0;
        endcase
    end

    // MISO two-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_p0 <= 1'b0;
            miso_p1 <= 1'b0;
        end else begin
            miso_p0 <= spi_miso;
            miso_p1 <= miso_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 3'd0;
            remaining <= 16'd0;
            spi_sclk  <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            spi_cs_n <= (next_state == IDLE) || (next_state == CFG);
            if (state == SHIFT || state == CS_HOLD)
                div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            else
                div <= '0;
            if (state == SHIFT) begin
                if (edge_tick) begin
                    phase    <= !phase;
                    spi_sclk <= !spi_sclk;
                end
                if (trail_edge) bit_cnt <= bit_cnt + 3'd1;
            end else begin
                phase    <= 1'b0;
                bit_cnt  <= 3'd0;
                spi_sclk <= cpol;
            end
            if (state == IDLE && (start_xfer || start_cfg))
                remaining <= cmd_length;
            else if ((state == PUSH || (state == CFG && accept)) && remaining != 16'd0)
                remaining <= remaining - 16'd1;
            if (state == WAIT_BYTE && accept)
                spi_mosi <= cmd_data[7];
            else if (update_edge)
                spi_mosi <= tx_sr[7];
        end
    end

    // In CPHA=0 the MSB is already on MOSI at load, so the shifter starts one bit ahead
    always_ff @(posedge clk) begin
        if (state == WAIT_BYTE && accept)
            tx_sr <= cpha ? cmd_data : {cmd_data[6:0], 1'b0};
        else if (update_edge)
            tx_sr <= {tx_sr[6:0], 1'b0};
        if (sample_edge)
            rx_sr <= {rx_sr[6:0], miso_p1};
        if (push)
            mem[wr_ptr] <= rx_sr;
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push       = (state == PUSH) && (!fifo_full || pop);
    assign pop        = upload_valid && upload_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign upload_valid  = !fifo_empty;
    assign upload_req    = !fifo_empty;
    assign upload_data   = fifo_empty ? 8'h00 : mem[rd_ptr];
    assign upload_source = UPLOAD_SOURCE;

endmodule

// File: tb/tb_spi_handler.sv
// Directed testbench for spi_handler (CLK_DIV=8); the mode-config scenario runs only when SPI_CFG_EN is defined.
module tb_spi_handler;
    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_type = 8'h00;
    logic [15:0] cmd_length = 16'h0000;
    logic [7:0]  cmd_data = 8'h00;
    logic [15:0] cmd_data_index = 16'h0000;
    logic        cmd_start = 1'b0;
    logic        cmd_data_valid = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_ready;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic        upload_req, upload_valid;
    logic [7:0]  upload_data, upload_source;
    logic        upload_ready = 1'b1;
    logic        loopback = 1'b1;
    logic        miso_val = 1'b0;
    logic        tb_cpol = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit         mosi_q[$];
    int         rise_q[$];
    logic [7:0] rx_q[$];
    int         last_trail = 0;
    int         cs_rise_cyc = 0;
    int         cs_rises = 0;
    int         cs_falls = 0;

    assign spi_miso = loopback ? spi_mosi : miso_val;

    spi_handler dut (
        .clk(clk), .rst_n(rst_n), .cmd_type(cmd_type), .cmd_length(cmd_length),
        .cmd_data(cmd_data), .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
        .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .upload_req(upload_req), .upload_data(upload_data), .upload_source(upload_source),
        .upload_valid(upload_valid), .upload_ready(upload_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus monitors: MOSI at leading edges, SCLK timing, chip-select activity, popped upload bytes
    always @(spi_sclk) begin
        if (rst_n && !spi_cs_n && spi_sclk == !tb_cpol) mosi_q.push_back(spi_mosi);
        if (spi_sclk == tb_cpol) last_trail = cyc;
    end
    always @(posedge spi_sclk) rise_q.push_back(cyc);
    always @(posedge spi_cs_n) begin cs_rises++; cs_rise_cyc = cyc; end
    always @(negedge spi_cs_n) cs_falls++;
    always @(negedge clk) if (rst_n && upload_valid && upload_ready) rx_q.push_back(upload_data);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon;
        mosi_q.delete(); rise_q.delete(); rx_q.delete();
        cs_rises = 0; cs_falls = 0;
    endtask

    task automatic start_cmd(input logic [7:0] t, input logic [15:0] len);
        cmd_type = t; cmd_length = len; cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [15:0] idx, output bit ok);
        bit acc = 1'b0;
        cmd_data = b; cmd_data_index = idx; cmd_data_valid = 1'b1;
        for (int i = 0; i < 4000 && !acc; i++) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_data_valid = 1'b0;
        ok = acc;
    endtask

    task automatic pulse_done;
        cmd_done = 1'b1; tick(1); cmd_done = 1'b0;
    endtask

    task automatic wait_cs_high(output bit ok);
        for (int i = 0; i < 5000 && !spi_cs_n; i++) @(negedge clk);
        ok = spi_cs_n;
        tick(1);
    endtask

    function automatic logic [31:0] pack_bits(input int from, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = {v[30:0], (from + i < mosi_q.size()) ? mosi_q[from + i] : 1'b0};
        return v;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        checks++; if (upload_req !== 1'b0) begin errors++; $display("FAIL reset_upload_req: got %b want 0", upload_req); end
        checks++; if (upload_valid !== 1'b0) begin errors++; $display("FAIL reset_upload_valid: got %b want 0", upload_valid); end
        checks++; if (upload_data !== 8'h00) begin errors++; $display("FAIL reset_upload_data: got %h want 00", upload_data); end
        checks++; if (upload_source !== 8'h11) begin errors++; $display("FAIL upload_source: got %h want 11", upload_source); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_byte;
        bit ok1, ok2;
        int period;
        clear_mon(); loopback = 1'b1; upload_ready = 1'b1;
        start_cmd(8'h11, 16'd1);
        send_byte(8'hA5, 16'd0, ok1);
        pulse_done();
        wait_cs_high(ok2);
        tick(3);
        period = (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1;
        checks++; if ((ok1 && ok2) !== 1'b1) begin errors++; $display("FAIL single_handshake: accepted=%b cs_released=%b want 1/1", ok1, ok2); end
        checks++; if (mosi_q.size() !== 8) begin errors++; $display("FAIL single_sclk_pulses: got %0d want 8", mosi_q.size()); end
        checks++; if (pack_bits(0, 8) !== 32'hA5) begin errors++; $display("FAIL single_mosi_bits: got %h want a5", pack_bits(0, 8)); end
        checks++; if (period !== 2 * CLK_DIV) begin errors++; $display("FAIL single_sclk_period: got %0d want %0d", period, 2 * CLK_DIV); end
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_upload_count: got %0d want 1", rx_q.size()); end
        checks++; if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'hA5) begin errors++; $display("FAIL single_upload_data: got %h want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
        // one PUSH cycle plus CLK_DIV hold cycles between the last trailing edge and cs_n release
        checks++; if (cs_rise_cyc - last_trail !== CLK_DIV + 1) begin errors++; $display("FAIL single_cs_hold: got %0d want %0d", cs_rise_cyc - last_trail, CLK_DIV + 1); end
    endtask

    task automatic test_multi_byte;
        bit ok, all_ok = 1'b1;
        logic [7:0] tx [3] = '{8'h01, 8'h80, 8'hFF};
        int bad = 0;
        clear_mon(); loopback = 1'b0; miso_val = 1'b1; upload_ready = 1'b1;
        start_cmd(8'h11, 16'd3);
        for (int i = 0; i < 3; i++) begin send_byte(tx[i], 16'(i), ok); all_ok &= ok; end
        wait_cs_high(ok); all_ok &= ok;
        tick(3);
        foreach (rx_q[i]) if (rx_q[i] !== 8'hFF) bad++;
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL multi_handshake: got %b want 1", all_ok); end
        checks++; if (rx_q.size() !== 3 || bad != 0) begin errors++; $display("FAIL multi_upload: got %0d bytes %0d not ff, want 3 bytes all ff", rx_q.size(), bad); end
        checks++; if (cs_falls !== 1 || cs_rises !== 1) begin errors++; $display("FAIL multi_cs_once: got falls=%0d rises=%0d want 1/1", cs_falls, cs_rises); end
        checks++; if (pack_bits(0, 24) !== 32'h0180FF) begin errors++; $display("FAIL multi_mosi_bits: got %h want 0180ff", pack_bits(0, 24)); end
        loopback = 1'b1; miso_val = 1'b0;
    endtask

    task automatic test_back_pressure;
        bit ok, all_ok = 1'b1, held = 1'b1;
        logic [7:0] exp_b [20];
        int bad = 0;
        for (int i = 0; i < 20; i++) exp_b[i] = 8'((i * 17 + 3) & 255);
        clear_mon(); loopback = 1'b1; upload_ready = 1'b0;
        start_cmd(8'h11, 16'd20);
        for (int i = 0; i < 16; i++) begin send_byte(exp_b[i], 16'(i), ok); all_ok &= ok; end
        tick(2 * 16 * CLK_DIV + 10);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", cmd_ready); end
        checks++; if (upload_req !== 1'b1) begin errors++; $display("FAIL bp_upload_req: got %b want 1", upload_req); end
        checks++; if (upload_data !== exp_b[0]) begin errors++; $display("FAIL bp_fifo_head: got %h want %h", upload_data, exp_b[0]); end
        cmd_data = exp_b[16]; cmd_data_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (cmd_ready) held = 1'b0; end
        tick(1);
        cmd_data_valid = 1'b0;
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL bp_ready_held: got %b want 1", held); end
        upload_ready = 1'b1;
        for (int i = 16; i < 20; i++) begin send_byte(exp_b[i], 16'(i), ok); all_ok &= ok; end
        wait_cs_high(ok); all_ok &= ok;
        tick(3);
        foreach (rx_q[i]) if (i < 20 && rx_q[i] !== exp_b[i]) bad++;
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL bp_handshake: got %b want 1", all_ok); end
        checks++; if (rx_q.size() !== 20 || bad != 0) begin errors++; $display("FAIL bp_upload_order: got %0d bytes %0d wrong, want 20 bytes in order", rx_q.size(), bad); end
        checks++; if (cs_rises !== 1) begin errors++; $display("FAIL bp_cs_continuous: got %0d releases want 1", cs_rises); end
    endtask

    task automatic test_ignored_cmds;
        clear_mon(); upload_ready = 1'b1;
        start_cmd(8'h05, 16'd4);
        for (int i = 0; i < 4; i++) begin cmd_data = 8'hC0 + 8'(i); cmd_data_valid = 1'b1; tick(1); cmd_data_valid = 1'b0; tick(1); end
        tick(20);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ign_type_ready: got %b want 1", cmd_ready); end
        start_cmd(8'h11, 16'd0);
        tick(20);
`ifndef SPI_CFG_EN
        start_cmd(8'h12, 16'd1);
        cmd_data = 8'h03; cmd_data_valid = 1'b1; tick(1); cmd_data_valid = 1'b0;
        tick(20);
`endif
        checks++; if (cs_falls !== 0) begin errors++; $display("FAIL ign_cs_activity: got %0d falls want 0", cs_falls); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ign_len0_ready: got %b want 1", cmd_ready); end
        checks++; if (upload_req !== 1'b0) begin errors++; $display("FAIL ign_upload_req: got %b want 0", upload_req); end
        checks++; if (rise_q.size() !== 0) begin errors++; $display("FAIL ign_sclk: got %0d pulses want 0", rise_q.size()); end
    endtask

    task automatic test_async_reset;
        bit ok, all_ok = 1'b1;
        clear_mon(); loopback = 1'b1; upload_ready = 1'b0;
        start_cmd(8'h11, 16'd2);
        send_byte(8'hC3, 16'd0, ok); all_ok &= ok;
        send_byte(8'h77, 16'd1, ok); all_ok &= ok;
        for (int i = 0; i < 3000 && mosi_q.size() < 12; i++) @(negedge clk);
        checks++; if (upload_req !== 1'b1 || mosi_q.size() !== 12) begin errors++; $display("FAIL rst_precond: got upload_req=%b bits=%0d want 1/12", upload_req, mosi_q.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mid_mosi: got %b want 0", spi_mosi); end
        checks++; if (upload_req !== 1'b0 || upload_data !== 8'h00) begin errors++; $display("FAIL rst_mid_fifo: got req=%b data=%h want 0/00", upload_req, upload_data); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
        clear_mon(); upload_ready = 1'b1;
        start_cmd(8'h11, 16'd1);
        send_byte(8'h3C, 16'd0, ok); all_ok &= ok;
        wait_cs_high(ok); all_ok &= ok;
        tick(3);
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL rst_handshake: got %b want 1", all_ok); end
        checks++; if (rx_q.size() !== 1 || (rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'h3C) begin errors++; $display("FAIL rst_after_xfer: got %0d bytes first=%h want 1 byte 3c", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
        checks++; if (pack_bits(0, 8) !== 32'h3C) begin errors++; $display("FAIL rst_after_mosi: got %h want 3c", pack_bits(0, 8)); end
    endtask

`ifdef SPI_CFG_EN
    task automatic test_mode_cfg;
        bit ok, all_ok = 1'b1;
        clear_mon(); loopback = 1'b1; upload_ready = 1'b1;
        start_cmd(8'h12, 16'd1);
        send_byte(8'h02, 16'd0, ok); all_ok &= ok;
        tick(5);
        checks++; if (spi_sclk !== 1'b1 || cs_falls !== 0) begin errors++; $display("FAIL cfg_idle: got sclk=%b cs_falls=%0d want 1/0", spi_sclk, cs_falls); end
        tb_cpol = 1'b1;
        start_cmd(8'h11, 16'd1);
        send_byte(8'h5A, 16'd0, ok); all_ok &= ok;
        wait_cs_high(ok); all_ok &= ok;
        tick(3);
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL cfg_handshake: got %b want 1", all_ok); end
        checks++; if (mosi_q.size() !== 8 || pack_bits(0, 8) !== 32'h5A) begin errors++; $display("FAIL cfg_mosi: got %0d bits value %h want 8 bits 5a", mosi_q.size(), pack_bits(0, 8)); end
        checks++; if (rx_q.size() !== 1 || (rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'h5A) begin errors++; $display("FAIL cfg_loopback: got %0d bytes first=%h want 1 byte 5a", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
        checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL cfg_sclk_idle_after: got %b want 1", spi_sclk); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_back_pressure();
        test_ignored_cmds();
        test_async_reset();
`ifdef SPI_CFG_EN
        test_mode_cfg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
